// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and defaults for the mux select sequencer.
// State encodings and default select/data widths.
package mux_sel_sequencer_pkg;

  localparam int SEL_W_DEF  = 3;
  localparam int DATA_W_DEF = 2 ** SEL_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mux_seq_dwell_cnt.sv
// Loadable dwell counter for the mux select sequencer.
// tc marks the last cycle a select value is held.
module mux_seq_dwell_cnt #(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Drives an 8:1 mux, scans its select and captures its output.
// Loopback check enabled by MUX_SEQ_LOOPBACK_CHECK_EN.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter  int SEL_W  = SEL_W_DEF,
  parameter  int DWELL  = 1,
  parameter  int CNT_W  = 8,
  localparam int DATA_W = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] d_out,
  output logic [SEL_W-1:0]  sel,
  input  logic              p_in,
  output logic              busy,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              done,
  output logic [DATA_W-1:0] cap_out,
  output logic              err
);

  seq_state_t        state;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] cap_next;
  logic              tc;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && tc &&
                  (sel == SEL_W'(DATA_W - 1));

  mux_seq_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == RUN),
    .tc    (tc)
  );

  always_comb begin
    cap_next      = cap;
    cap_next[sel] = p_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_out     <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      cap_out   <= '0;
      cap       <= '0;
    end else begin
      ser_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_out <= data_in;
            sel   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (tc) begin
            cap       <= cap_next;
            ser_bit   <= p_in;
            ser_valid <= 1'b1;
            if (last) begin
              state   <= DONE;
              done    <= 1'b1;
              cap_out <= cap_next;
            end else begin
              sel <= sel + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_SEQ_LOOPBACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (last) begin
      err <= (cap_next != d_out);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: DWELL=1 and DWELL=3 instances
// against a timeline model of the scan.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic       fault;

  logic [7:0] dout_w [2];
  logic [2:0] sel_w  [2];
  logic [7:0] cap_w  [2];
  logic       p_w    [2];
  logic       busy_w [2];
  logic       sbit_w [2];
  logic       sv_w   [2];
  logic       done_w [2];
  logic       err_w  [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // behavioural 8:1 mux, optional stuck-at-0 on input 3
  assign p_w[0] = dout_w[0][sel_w[0]] & ~(fault && sel_w[0] == 3'd3);
  assign p_w[1] = dout_w[1][sel_w[1]] & ~(fault && sel_w[1] == 3'd3);

  mux_sel_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .d_out(dout_w[0]), .sel(sel_w[0]), .p_in(p_w[0]),
    .busy(busy_w[0]), .ser_bit(sbit_w[0]), .ser_valid(sv_w[0]),
    .done(done_w[0]), .cap_out(cap_w[0]), .err(err_w[0])
  );

  mux_sel_sequencer #(.DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .d_out(dout_w[1]), .sel(sel_w[1]), .p_in(p_w[1]),
    .busy(busy_w[1]), .ser_bit(sbit_w[1]), .ser_valid(sv_w[1]),
    .done(done_w[1]), .cap_out(cap_w[1]), .err(err_w[1])
  );

  // model: tt = cycles since the accept edge (0 = cycle right after it)
  bit         ever  [2];
  int         tt    [2];
  logic [7:0] mdata [2];
  bit         mflt  [2];
  logic [7:0] pcap  [2];
  bit         pbit  [2];

  function automatic int dw(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] eff(input int i);
    return mdata[i] & ~(mflt[i] ? 8'h08 : 8'h00);
  endfunction

  function automatic bit e_busy(input int i);
    return ever[i] && tt[i] <= 8 * dw(i);
  endfunction

  function automatic logic [2:0] e_sel(input int i);
    int n;
    if (!ever[i]) return 3'd0;
    n = tt[i] / dw(i);
    if (n > 7) n = 7;
    return 3'(n);
  endfunction

  function automatic bit e_sv(input int i);
    return ever[i] && tt[i] > 0 && (tt[i] % dw(i)) == 0 &&
           (tt[i] / dw(i)) <= 8;
  endfunction

  function automatic bit e_sbit(input int i);
    int n;
    logic [7:0] e;
    if (!ever[i]) return 1'b0;
    n = tt[i] / dw(i);
    if (n == 0) return pbit[i];
    if (n > 8) n = 8;
    e = eff(i);
    return e[n-1];
  endfunction

  function automatic bit e_done(input int i);
    return ever[i] && tt[i] == 8 * dw(i);
  endfunction

  function automatic logic [7:0] e_cap(input int i);
    return (ever[i] && tt[i] >= 8 * dw(i)) ? eff(i) : pcap[i];
  endfunction

  function automatic bit e_err(input int i);
`ifdef MUX_SEQ_LOOPBACK_CHECK_EN
    return ever[i] && tt[i] >= 8 * dw(i) && eff(i) != mdata[i];
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ever[i]  <= 1'b0;
        tt[i]    <= 0;
        mdata[i] <= 8'h00;
        mflt[i]  <= 1'b0;
        pcap[i]  <= 8'h00;
        pbit[i]  <= 1'b0;
      end else if ((!ever[i] || tt[i] > 8 * dw(i)) && start) begin
        pcap[i]  <= e_cap(i);
        pbit[i]  <= e_sbit(i);
        ever[i]  <= 1'b1;
        tt[i]    <= 0;
        mdata[i] <= data_in;
        mflt[i]  <= fault;
      end else if (ever[i] && tt[i] < 1000) begin
        tt[i] <= tt[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dw%0d_d_out", dw(i)), dout_w[i],
          ever[i] ? mdata[i] : 8'h00);
      chk($sformatf("dw%0d_sel", dw(i)), sel_w[i], e_sel(i));
      chk($sformatf("dw%0d_busy", dw(i)), busy_w[i], e_busy(i));
      chk($sformatf("dw%0d_ser_valid", dw(i)), sv_w[i], e_sv(i));
      chk($sformatf("dw%0d_ser_bit", dw(i)), sbit_w[i], e_sbit(i));
      chk($sformatf("dw%0d_done", dw(i)), done_w[i], e_done(i));
      chk($sformatf("dw%0d_cap_out", dw(i)), cap_w[i], e_cap(i));
      chk($sformatf("dw%0d_err", dw(i)), err_w[i], e_err(i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!busy_w[0] && !busy_w[1]) break;
      step();
    end
    chk("idle_wait", {busy_w[0], busy_w[1]}, 2'b00);
  endtask

  // directed scan with literal expectations; poke>=0 pulses a start mid-scan
  task automatic scan_lit(input logic [7:0] dat, input logic [7:0] exp_cap,
                          input bit exp_err, input int poke);
    int         nb [2];
    int         nv [2];
    int         nd [2];
    int         dc [2];
    logic [7:0] sb [2];
    logic [7:0] cv [2];
    bit         ev [2];
    wait_idle();
    data_in = dat;
    start   = 1'b1;
    step();
    start   = 1'b0;
    data_in = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; nv[i] = 0; nd[i] = 0; dc[i] = -1;
      sb[i] = 8'h00; cv[i] = 8'h00; ev[i] = 1'b0;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (busy_w[i]) nb[i]++;
        if (sv_w[i] && nv[i] < 8) begin
          sb[i][nv[i]] = sbit_w[i];
          nv[i]++;
        end
        if (done_w[i]) begin
          nd[i]++;
          dc[i] = c;
          cv[i] = cap_w[i];
          ev[i] = err_w[i];
        end
      end
      @(posedge clk);
      #1;
      if (c == poke) begin
        start   = 1'b1;
        data_in = 8'hFF;
      end else if (c == poke + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lit_dw%0d_busy_cycles", dw(i)), nb[i], 9 + 16 * i);
      chk($sformatf("lit_dw%0d_strobes", dw(i)), nv[i], 8);
      chk($sformatf("lit_dw%0d_serial", dw(i)), sb[i], exp_cap);
      chk($sformatf("lit_dw%0d_done_cnt", dw(i)), nd[i], 1);
      chk($sformatf("lit_dw%0d_done_cyc", dw(i)), dc[i], 8 + 16 * i);
      chk($sformatf("lit_dw%0d_cap", dw(i)), cv[i], exp_cap);
      chk($sformatf("lit_dw%0d_err", dw(i)), ev[i], exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo [2];
    bit le;
`ifdef MUX_SEQ_LOOPBACK_CHECK_EN
    le = 1'b1;
`else
    le = 1'b0;
`endif
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 8'h00;
    fault   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      data_in = 8'($urandom);
      step();
    end

    scan_lit(8'hA5, 8'hA5, 1'b0, -5);
    scan_lit(8'h3C, 8'h3C, 1'b0, -5);
    scan_lit(8'h0F, 8'h0F, 1'b0, 3);

    // start held through DONE: dw1 relaunches after one idle cycle
    wait_idle();
    data_in = 8'h42;
    start   = 1'b1;
    step();
    lo[0] = 0;
    lo[1] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (!busy_w[i]) lo[i]++;
      step();
    end
    start = 1'b0;
    chk("lit_held_dw1_idle_cycles", lo[0], 1);
    chk("lit_held_dw3_idle_cycles", lo[1], 0);

    // reset in the middle of a scan
    wait_idle();
    data_in = 8'h5A;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lit_rst_dw%0d_busy", dw(i)), busy_w[i], 1'b0);
      chk($sformatf("lit_rst_dw%0d_cap", dw(i)), cap_w[i], 8'h00);
      chk($sformatf("lit_rst_dw%0d_sel", dw(i)), sel_w[i], 3'd0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    scan_lit(8'h81, 8'h81, 1'b0, -5);

    // stuck-at-0 on mux input 3, then a clean scan
    wait_idle();
    fault = 1'b1;
    scan_lit(8'hFF, 8'hF7, le, -5);
    wait_idle();
    fault = 1'b0;
    scan_lit(8'hFF, 8'hFF, 1'b0, -5);

    for (int c = 0; c < 400; c++) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      step();
    end
    start = 1'b0;
    wait_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
